cr_bitstream_unpacker: RTL and testbench
========================================

// Module: cr_bitstream_unpacker
// PURPOSE
//  Sink for the Cr Huffman encoder bitstream interface.
//  - Accepts 32-bit packed words (MSB first) and splits them into bytes.
//  - Inserts 0x00 after every 0xFF byte (JPEG byte stuffing).
//  - On flush, pads the final partial word with 1s and emits it.
//  - Feeds the file/stream writer through a valid/ready byte port.
// PARAMETERS
//  DEPTH  4  word FIFO depth (power of 2, >=2)
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous active-high reset
//  data_ready          in   1   JPEG_bitstream holds 32 valid bits; 1-cycle pulse
//  JPEG_bitstream      in   32  packed Huffman bits, MSB first, left-aligned
//  output_reg_count    in   5   valid residual bits in JPEG_bitstream at flush (0..31)
//  end_of_block_empty  in   1   flush: final residual of the image, 1-cycle pulse
//  byte_out            out  8   output byte
//  byte_valid          out  1   byte_out is valid
//  byte_ready          in   1   downstream accepts byte_out this cycle
//  fifo_full           out  1   word FIFO holds DEPTH entries
//  overflow            out  1   sticky: a word was dropped
//  flush_done          out  1   1-cycle pulse after the last byte of a flush is accepted
// BEHAVIOUR
//  Reset:
//   - All outputs are 0. FIFO is empty. FSM is in IDLE.
//   - rst mid-operation discards queued words and any held byte.
//  FIFO entry format: {data[31:0], nbytes[2:0], last}.
//   - data_ready=1 and FIFO not full: enqueue {JPEG_bitstream, 4, 0}.
//   - Flush with count n: enqueue {JPEG_bitstream | (32'hFFFF_FFFF >> n), ceil(n/8), 1}.
//     This pads with 1s up to the byte boundary.
//   - data_ready and end_of_block_empty in the same cycle:
//     - Cycle 1: enqueue the full word.
//     - Next cycle: enqueue a flush entry with n=0.
//     - Two free slots are required; otherwise apply the overflow rule.
//   - Enqueue while full: the entry is dropped and overflow is set until rst.
//   - Simultaneous enqueue and dequeue while full is allowed; no data is lost.
//  FSM:
//   - IDLE: if FIFO is not empty, pop the entry into the shift register and go to LOAD.
//   - LOAD:
//     - nbytes=0 and last=1: pulse flush_done, go to IDLE.
//     - Otherwise: byte_out = data[31:24], byte_valid=1, go to EMIT.
//   - EMIT, on handshake (byte_valid & byte_ready):
//     - If byte_out == 8'hFF: go to STUFF with byte_out = 8'h00.
//     - Else if bytes remain: shift left by 8, present the next byte.
//     - Else if last=1: pulse flush_done, go to IDLE.
//     - Else: go to IDLE, or pop the next entry directly into LOAD.
//   - STUFF: on handshake, same "bytes remain / last / next" decision as EMIT.
//  Handshake rules:
//   - byte_out and byte_valid stay stable while byte_valid & !byte_ready.
//   - byte_valid never drops without a handshake, except on rst.
//  Timing:
//   - Latency: data_ready in cycle N gives the first byte_valid in cycle N+2.
//   - Throughput: 1 byte per cycle while byte_ready=1.
//   - A word with no 0xFF bytes takes 4 handshakes.
//  Padding:
//   - A padded byte that becomes 0xFF is stuffed like any other 0xFF.
//   - n=0 emits no bytes, only flush_done.
//  fifo_full is combinational from the FIFO count. It is registered-accurate in the same cycle.
// TESTING
//  T1: word 0x12345678, byte_ready=1
//      -> bytes 12,34,56,78 on 4 consecutive cycles, first byte at N+2.
//  T2: word 0xFF00FFAB
//      -> bytes FF,00,00,FF,00,AB.
//  T3: flush with JPEG_bitstream=0xABC00000, count=12
//      -> bytes AB,CF, then flush_done.
//  T3b: flush with JPEG_bitstream=0xF0000000, count=4
//      -> bytes FF,00, then flush_done.
//  T3c: flush with count=0
//      -> no bytes, flush_done 2 cycles later.
//  T4: byte_ready=0 for 5 cycles during word 0xA1B2C3D4
//      -> byte_out holds A1 with byte_valid=1, then A1,B2,C3,D4 on release.
//  T5: byte_ready=0, DEPTH+2 data_ready pulses
//      -> fifo_full=1 and overflow=1; on release exactly DEPTH+1 words are emitted
//         (one held in the shift register, DEPTH in the FIFO).
//  T6: rst asserted during EMIT of word 2 of 3
//      -> next cycle byte_valid=0, overflow=0, FIFO empty; no stale bytes after reset.

Source files
------------

// File: rtl/cr_bitstream_unpacker.sv
// Cr Huffman bitstream sink: buffers 32-bit packed words in a small FIFO,
// splits them into bytes MSB first, inserts 0x00 after every 0xFF and pads
// the final partial word with 1s on flush.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   data_ready          JPEG_bitstream holds a full 32-bit word (pulse)
//   JPEG_bitstream      packed bits, MSB first, left-aligned
//   output_reg_count    valid residual bits at flush (0..31)
//   end_of_block_empty  flush request for the final residual (pulse)
//   byte_out/byte_valid/byte_ready  downstream byte handshake
//   fifo_full           word FIFO holds DEPTH entries (combinational)
//   overflow            sticky, set when a word was dropped
//   flush_done          pulse after the last byte of a flush is accepted
module cr_bitstream_unpacker #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_ready,
   input  logic [31:0] JPEG_bitstream,
   input  logic [4:0]  output_reg_count,
   input  logic        end_of_block_empty,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        fifo_full,
   output logic        overflow,
   output logic        flush_done
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  nbytes;
      logic        last;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EMIT,
      S_STUFF
   } state_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            fifo_empty;
   entry_t          head;

   state_t          state, state_nxt;
   logic [31:0]     sh_data, sh_data_nxt;
   logic [2:0]      rem, rem_nxt;
   logic            cur_last, cur_last_nxt;
   logic [7:0]      byte_out_nxt;
   logic            byte_valid_nxt;
   logic            flush_done_nxt;
   logic            overflow_nxt;
   logic            pend_flush, pend_flush_nxt;

   logic            push_req_c, push_c, pop_c, drop_c, advance_c;
   entry_t          push_entry_c;
   logic [5:0]      ceil_sum_c;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(DEPTH));
   assign head       = mem[rd_ptr];
   assign ceil_sum_c = {1'b0, output_reg_count} + 6'd7;

   // Enqueue arbitration. A same-cycle word + flush becomes a word now and
   // an n=0 flush entry next cycle; anything else arriving that cycle is lost.
   always_comb begin
      push_req_c     = 1'b0;
      push_entry_c   = '0;
      pend_flush_nxt = pend_flush;
      drop_c         = 1'b0;
      if (pend_flush) begin
         push_req_c     = 1'b1;
         push_entry_c   = '{data: 32'hFFFF_FFFF, nbytes: 3'd0, last: 1'b1};
         pend_flush_nxt = 1'b0;
         drop_c         = data_ready | end_of_block_empty;
      end else if (data_ready) begin
         push_req_c     = 1'b1;
         push_entry_c   = '{data: JPEG_bitstream, nbytes: 3'd4, last: 1'b0};
         pend_flush_nxt = end_of_block_empty;
      end else if (end_of_block_empty) begin
         push_req_c   = 1'b1;
         push_entry_c = '{data:   JPEG_bitstream | (32'hFFFF_FFFF >> output_reg_count),
                          nbytes: ceil_sum_c[5:3],
                          last:   1'b1};
      end
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_c       = push_req_c & (~fifo_full | pop_c);
      overflow_nxt = overflow | drop_c | (push_req_c & ~push_c);
   end

   // Word FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) begin
            mem[wr_ptr] <= push_entry_c;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push_c) - CW'(pop_c);
      end
   end

   // Byte FSM next state. Loading an entry presents its first byte on the
   // same edge that pops it, giving first byte_valid two cycles after input.
   always_comb begin
      state_nxt      = state;
      sh_data_nxt    = sh_data;
      rem_nxt        = rem;
      cur_last_nxt   = cur_last;
      byte_out_nxt   = byte_out;
      byte_valid_nxt = byte_valid;
      flush_done_nxt = 1'b0;
      pop_c          = 1'b0;
      advance_c      = 1'b0;

      case (state)
         S_IDLE: begin
            if (!fifo_empty) pop_c = 1'b1;
         end
         S_EMIT: begin
            if (byte_valid && byte_ready) begin
               if (byte_out == 8'hFF) begin
                  byte_out_nxt = 8'h00;
                  state_nxt    = S_STUFF;
               end else begin
                  advance_c = 1'b1;
               end
            end
         end
         S_STUFF: begin
            if (byte_valid && byte_ready) advance_c = 1'b1;
         end
         default: begin
            state_nxt      = S_IDLE;
            byte_valid_nxt = 1'b0;
         end
      endcase

      // Move past the accepted byte: next byte, end of flush, or next entry.
      if (advance_c) begin
         if (rem != 3'd0) begin
            sh_data_nxt  = {sh_data[23:0], 8'h00};
            byte_out_nxt = sh_data[23:16];
            rem_nxt      = rem - 3'd1;
            state_nxt    = S_EMIT;
         end else begin
            byte_valid_nxt = 1'b0;
            state_nxt      = S_IDLE;
            if (cur_last) flush_done_nxt = 1'b1;
            else if (!fifo_empty) pop_c = 1'b1;
         end
      end

      if (pop_c) begin
         sh_data_nxt  = head.data;
         byte_out_nxt = head.data[31:24];
         cur_last_nxt = head.last;
         if (head.nbytes == 3'd0) begin
            byte_valid_nxt = 1'b0;
            flush_done_nxt = head.last;
            rem_nxt        = 3'd0;
            state_nxt      = S_IDLE;
         end else begin
            byte_valid_nxt = 1'b1;
            rem_nxt        = head.nbytes - 3'd1;
            state_nxt      = S_EMIT;
         end
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         sh_data    <= '0;
         rem        <= '0;
         cur_last   <= 1'b0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         flush_done <= 1'b0;
         overflow   <= 1'b0;
         pend_flush <= 1'b0;
      end else begin
         state      <= state_nxt;
         sh_data    <= sh_data_nxt;
         rem        <= rem_nxt;
         cur_last   <= cur_last_nxt;
         byte_out   <= byte_out_nxt;
         byte_valid <= byte_valid_nxt;
         flush_done <= flush_done_nxt;
         overflow   <= overflow_nxt;
         pend_flush <= pend_flush_nxt;
      end
   end

endmodule

// File: tb/tb_cr_bitstream_unpacker.sv
// Self-checking bench for cr_bitstream_unpacker: table of single-transaction
// vectors plus hand-written latency, back-pressure, overflow and reset cases.
module tb_cr_bitstream_unpacker;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_ready;
   logic [31:0] JPEG_bitstream;
   logic [4:0]  output_reg_count;
   logic        end_of_block_empty;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        fifo_full;
   logic        overflow;
   logic        flush_done;

   cr_bitstream_unpacker #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .data_ready         (data_ready),
      .JPEG_bitstream     (JPEG_bitstream),
      .output_reg_count   (output_reg_count),
      .end_of_block_empty (end_of_block_empty),
      .byte_out           (byte_out),
      .byte_valid         (byte_valid),
      .byte_ready         (byte_ready),
      .fifo_full          (fifo_full),
      .overflow           (overflow),
      .flush_done         (flush_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] got[$];
   int         gotc[$];
   int         n_done;
   int         done_cyc;
   int         n_vec = 0;
   int         n_err = 0;

   // Capture accepted bytes and flush_done pulses away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (byte_valid && byte_ready) begin
            got.push_back(byte_out);
            gotc.push_back(cyc);
         end
         if (flush_done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_capture();
      got.delete();
      gotc.delete();
      n_done   = 0;
      done_cyc = -1;
   endtask

   // Called right after a posedge; inputs are sampled on the next posedge.
   task automatic pulse(input logic [31:0] w, input logic [4:0] n,
                        input logic dr, input logic eob);
      JPEG_bitstream     = w;
      output_reg_count   = n;
      data_ready         = dr;
      end_of_block_empty = eob;
      @(posedge clk); #1;
      data_ready         = 1'b0;
      end_of_block_empty = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      logic [31:0] word;
      logic [4:0]  cnt;
      logic        dr;
      logic        eob;
      int          nexp;
      logic [63:0] exp;
      int          ndone;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{"t1_word",   32'h1234_5678, 5'd0,  1'b1, 1'b0, 4, 64'h1234_5678_0000_0000, 0};
      vt[1] = '{"t2_stuff",  32'hFF00_FFAB, 5'd0,  1'b1, 1'b0, 6, 64'hFF00_00FF_00AB_0000, 0};
      vt[2] = '{"t3_flush",  32'hABC0_0000, 5'd12, 1'b0, 1'b1, 2, 64'hABCF_0000_0000_0000, 1};
      vt[3] = '{"t3b_padff", 32'hF000_0000, 5'd4,  1'b0, 1'b1, 2, 64'hFF00_0000_0000_0000, 1};
      vt[4] = '{"t3c_zero",  32'h5555_5555, 5'd0,  1'b0, 1'b1, 0, 64'h0,                   1};
      vt[5] = '{"both",      32'h1122_3344, 5'd0,  1'b1, 1'b1, 4, 64'h1122_3344_0000_0000, 1};
      vt[6] = '{"flush31",   32'h1234_5678, 5'd31, 1'b0, 1'b1, 4, 64'h1234_5679_0000_0000, 1};

      rst = 1'b1; data_ready = 1'b0; end_of_block_empty = 1'b0;
      JPEG_bitstream = '0; output_reg_count = '0; byte_ready = 1'b1;
      n_done = 0; done_cyc = -1;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_byte_valid", 32'(byte_valid), 32'd0);
      chk("rst_byte_out",   32'(byte_out),   32'd0);
      chk("rst_fifo_full",  32'(fifo_full),  32'd0);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      @(posedge clk); #1;

      // Table-driven single transactions.
      for (int v = 0; v < 7; v++) begin
         clear_capture();
         pulse(vt[v].word, vt[v].cnt, vt[v].dr, vt[v].eob);
         idle(20);
         chk({vt[v].name, "_nbytes"}, 32'(got.size()), 32'(vt[v].nexp));
         for (int i = 0; i < vt[v].nexp && i < got.size(); i++)
            chk($sformatf("%s_b%0d", vt[v].name, i), 32'(got[i]), 32'(vt[v].exp[63-8*i -: 8]));
         chk({vt[v].name, "_done"}, 32'(n_done), 32'(vt[v].ndone));
      end

      // Latency and back-to-back throughput of a plain word.
      begin
         int t0;
         clear_capture();
         t0 = cyc;
         pulse(32'h1234_5678, 5'd0, 1'b1, 1'b0);
         idle(10);
         chk("lat_nbytes", 32'(got.size()), 32'd4);
         if (got.size() == 4) begin
            for (int i = 0; i < 4; i++)
               chk($sformatf("lat_cycle%0d", i), 32'(gotc[i] - t0), 32'(2 + i));
         end
      end

      // Zero-count flush: flush_done two cycles after the request.
      begin
         int t0;
         clear_capture();
         t0 = cyc;
         pulse(32'h0, 5'd0, 1'b0, 1'b1);
         idle(8);
         chk("zero_done_cycle", 32'(done_cyc - t0), 32'd2);
         chk("zero_nbytes", 32'(got.size()), 32'd0);
      end

      // Back-pressure: first byte held stable, then released in order.
      clear_capture();
      byte_ready = 1'b0;
      pulse(32'hA1B2_C3D4, 5'd0, 1'b1, 1'b0);
      idle(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("hold_valid%0d", i), 32'(byte_valid), 32'd1);
         chk($sformatf("hold_byte%0d", i),  32'(byte_out),   32'hA1);
      end
      @(posedge clk); #1;
      byte_ready = 1'b1;
      idle(10);
      chk("hold_nbytes", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         chk($sformatf("hold_rel%0d", i), 32'(got[i]), 32'(8'hA1 + 8'(i) * 8'h11));

      // Overflow: DEPTH+2 words with the sink stalled.
      clear_capture();
      byte_ready = 1'b0;
      for (int i = 1; i <= DEPTH + 2; i++)
         pulse({4{8'(i)}}, 5'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("ovf_fifo_full", 32'(fifo_full), 32'd1);
      chk("ovf_overflow",  32'(overflow),  32'd1);
      @(posedge clk); #1;
      byte_ready = 1'b1;
      idle(40);
      chk("ovf_nbytes", 32'(got.size()), 32'(4 * (DEPTH + 1)));
      for (int i = 0; i < got.size() && i < 4 * (DEPTH + 1); i++)
         chk($sformatf("ovf_b%0d", i), 32'(got[i]), 32'(i / 4 + 1));
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Reset in the middle of the second of three words.
      clear_capture();
      for (int i = 0; i < 3; i++)
         pulse({4{8'hB0 + 8'(i)}}, 5'd0, 1'b1, 1'b0);
      for (int k = 0; k < 30 && got.size() < 5; k++) @(negedge clk);
      chk("rst_mid_reached", 32'(got.size() >= 5), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_valid",     32'(byte_valid), 32'd0);
      chk("rst_mid_overflow",  32'(overflow),   32'd0);
      chk("rst_mid_fifo_full", 32'(fifo_full),  32'd0);
      clear_capture();
      idle(15);
      chk("rst_mid_stale", 32'(got.size()), 32'd0);
      chk("rst_mid_done",  32'(n_done),     32'd0);

      // Recovery after reset.
      pulse(32'hC0FF_EE01, 5'd0, 1'b1, 1'b0);
      idle(12);
      chk("recover_nbytes", 32'(got.size()), 32'd5);
      if (got.size() == 5) begin
         chk("recover_b1", 32'(got[1]), 32'hFF);
         chk("recover_b2", 32'(got[2]), 32'h00);
         chk("recover_b4", 32'(got[4]), 32'h01);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
